multi_ro_rng_collector: RTL and testbench

MULTI_RO_RNG_COLLECTOR -- requirements
Module: multi_ro_rng_collector

---
 rtl/multi_ro_rng_collector_if.sv | 23 ++
 rtl/multi_ro_rng_collector.sv | 157 +++++++++++++++
 tb/tb_multi_ro_rng_collector.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_ro_rng_collector_if.sv
// Entropy collector port bundle: raw ring-oscillator inputs, run control and the output word handshake.
interface multi_ro_rng_collector_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
) ();
    logic [NCH-1:0]   ro_bits;
    logic             enable;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_word;
    logic             health_fail;
    logic             busy;

    modport master (
        input  ro_bits, enable, out_ready,
        output out_valid, out_word, health_fail, busy
    );

    modport slave (
        output ro_bits, enable, out_ready,
        input  out_valid, out_word, health_fail, busy
    );
endinterface

// File: rtl/multi_ro_rng_collector.sv
// Purpose: XOR-combines synchronized ring-oscillator channels, optional von Neumann debias, packs WIDTH-bit words.
// Latency: one raw bit per DECIM cycles; a word appears the cycle after its last accepted bit.
// Backpressure: a finished word with the output still occupied parks in STALL with the divider frozen.
module multi_ro_rng_collector #(
    parameter int NCH        = 4,
    parameter int WIDTH      = 8,
    parameter int DECIM      = 16,
    parameter int VN_EN      = 1,
    parameter int RCT_CUTOFF = 32
) (
    input  logic                  clk,
    input  logic                  rst_b,
    multi_ro_rng_collector_if.master bus
);
    localparam int DIV_W = $clog2(DECIM);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, COLLECT, STALL, FAIL} state_t;

    state_t           state, state_nxt;
    logic [NCH-1:0]   sync_q1, sync_q2;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shreg, out_word_q, word_nxt;
    logic             out_valid_q;
    logic             vn_have, vn_first;
    logic [7:0]       rct_cnt, rct_nxt;
    logic             prev_bit;
    logic             raw_bit, tick, rct_trip, acc_vld, acc_bit, word_done, handshake;

    assign raw_bit   = ^sync_q2;
    assign handshake = out_valid_q && bus.out_ready;
    assign tick      = (state == COLLECT) && bus.enable && (div_cnt == DIV_W'(DECIM - 1));

    always_comb begin
        rct_nxt = 8'd1;
        if ((rct_cnt != 8'd0) && (raw_bit == prev_bit))
            rct_nxt = (rct_cnt == 8'd255) ? rct_cnt : rct_cnt + 8'd1;
        rct_trip = tick && (rct_nxt >= 8'(RCT_CUTOFF));

        // Debiased bit is the first of a differing pair
        acc_vld = 1'b0;
        acc_bit = raw_bit;
        if (tick) begin
            if (VN_EN == 0) begin
                acc_vld = 1'b1;
            end else if (vn_have && (vn_first != raw_bit)) begin
                acc_vld = 1'b1;
                acc_bit = vn_first;
            end
        end
        word_nxt  = {shreg[WIDTH-2:0], acc_bit};
        word_done = acc_vld && (bit_cnt == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.enable) state_nxt = COLLECT;
            COLLECT: begin
                if (!bus.enable)
                    state_nxt = IDLE;
                else if (rct_trip)
                    state_nxt = FAIL;
                else if (word_done && out_valid_q && !bus.out_ready)
                    state_nxt = STALL;
            end
            STALL: begin
                if (!bus.enable)
                    state_nxt = IDLE;
                else if (handshake)
                    state_nxt = COLLECT;
            end
            FAIL:    state_nxt = FAIL;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            sync_q1     <= '0;
            sync_q2     <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            vn_have     <= 1'b0;
            vn_first    <= 1'b0;
            rct_cnt     <= 8'd0;
            prev_bit    <= 1'b0;
        end else begin
            sync_q1 <= bus.ro_bits;
            sync_q2 <= sync_q1;

            // Health state survives IDLE; only reset clears it
            if (tick) begin
                prev_bit <= raw_bit;
                rct_cnt  <= rct_nxt;
            end

            if (handshake)
                out_valid_q <= 1'b0;

            if (state_nxt == FAIL) begin
                out_valid_q <= 1'b0;
                shreg       <= '0;
                bit_cnt     <= '0;
                div_cnt     <= '0;
                vn_have     <= 1'b0;
            end else if ((state_nxt == IDLE) || (state == IDLE)) begin
                shreg   <= '0;
                bit_cnt <= '0;
                div_cnt <= '0;
                vn_have <= 1'b0;
            end else if (state == COLLECT) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick && (VN_EN != 0)) begin
                    vn_have  <= !vn_have;
                    vn_first <= raw_bit;
                end
                if (acc_vld) begin
                    if (word_done) begin
                        bit_cnt <= '0;
                        if (!out_valid_q || bus.out_ready) begin
                            out_word_q  <= word_nxt;
                            out_valid_q <= 1'b1;
                            shreg       <= '0;
                        end else begin
                            shreg <= word_nxt;
                        end
                    end else begin
                        shreg   <= word_nxt;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end else if ((state == STALL) && handshake) begin
                out_word_q  <= shreg;
                out_valid_q <= 1'b1;
                div_cnt     <= '0;
                shreg       <= '0;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_word    = out_word_q;
    assign bus.busy        = (state != IDLE);
    assign bus.health_fail = (state == FAIL);
endmodule

// File: tb/tb_multi_ro_rng_collector.sv
// Bench for multi_ro_rng_collector: one raw-bit instance and one debiased instance behind word scoreboards.
module tb_multi_ro_rng_collector;
    localparam int DECIM = 4;

    logic       clk;
    logic       rst_b;
    logic [3:0] ro_bits;
    logic       en_raw, en_vn, out_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sb_raw[$];
    logic [7:0] sb_vn[$];
    bit         sb_on    = 1'b1;
    bit         vn_phase = 1'b0;
    logic [7:0] acc_raw, acc_vn;
    int         cnt_raw, cnt_vn;
    bit         vn_have_m, vn_first_m;

    multi_ro_rng_collector_if #(.NCH(4), .WIDTH(8)) if_raw ();
    multi_ro_rng_collector_if #(.NCH(4), .WIDTH(8)) if_vn ();

    assign if_raw.ro_bits   = ro_bits;
    assign if_raw.enable    = en_raw;
    assign if_raw.out_ready = out_ready;
    assign if_vn.ro_bits    = ro_bits;
    assign if_vn.enable     = en_vn;
    assign if_vn.out_ready  = out_ready;

    multi_ro_rng_collector #(.NCH(4), .WIDTH(8), .DECIM(DECIM), .VN_EN(0), .RCT_CUTOFF(32)) u_raw (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (if_raw)
    );

    multi_ro_rng_collector #(.NCH(4), .WIDTH(8), .DECIM(DECIM), .VN_EN(1), .RCT_CUTOFF(32)) u_vn (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (if_vn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        cnt_raw   = 0;
        cnt_vn    = 0;
        acc_raw   = 8'h00;
        acc_vn    = 8'h00;
        vn_have_m = 1'b0;
    endtask

    task automatic model_bit(input bit b);
        if (!vn_phase) begin
            acc_raw = {acc_raw[6:0], b};
            cnt_raw++;
            if (cnt_raw == 8) begin
                sb_raw.push_back(acc_raw);
                cnt_raw = 0;
            end
        end else if (!vn_have_m) begin
            vn_first_m = b;
            vn_have_m  = 1'b1;
        end else begin
            vn_have_m = 1'b0;
            if (vn_first_m != b) begin
                acc_vn = {acc_vn[6:0], vn_first_m};
                cnt_vn++;
                if (cnt_vn == 8) begin
                    sb_vn.push_back(acc_vn);
                    cnt_vn = 0;
                end
            end
        end
    endtask

    // Called at a falling edge; the channel pattern is held for one full sample period
    task automatic drive_tick(input bit b);
        logic [3:0] r;
        r    = 4'($urandom);
        r[3] = (^r[2:0]) ^ b;
        ro_bits = r;
        model_bit(b);
        repeat (DECIM) @(negedge clk);
    endtask

    task automatic start_collect(input bit use_vn);
        if (use_vn) en_vn = 1'b1;
        else        en_raw = 1'b1;
        @(negedge clk);
    endtask

    task automatic stop_collect();
        en_raw = 1'b0;
        en_vn  = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    // Output monitors: a word leaves the DUT whenever valid and ready meet
    always @(negedge clk) begin
        logic [63:0] exp;
        #1;
        if (sb_on && if_raw.out_valid && if_raw.out_ready) begin
            exp = (sb_raw.size() != 0) ? 64'(sb_raw.pop_front()) : 64'hDEAD_BEEF;
            check("raw_word", 64'(if_raw.out_word), exp);
        end
        if (sb_on && if_vn.out_valid && if_vn.out_ready) begin
            exp = (sb_vn.size() != 0) ? 64'(sb_vn.pop_front()) : 64'hDEAD_BEEF;
            check("vn_word", 64'(if_vn.out_word), exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit pat_b2[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bit pat_vn[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_b = 1'b0; ro_bits = 4'h0; en_raw = 1'b0; en_vn = 1'b0; out_ready = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(if_raw.out_valid), 64'd0);
        check("rst_word", 64'(if_raw.out_word), 64'd0);
        check("rst_health", 64'(if_raw.health_fail), 64'd0);
        check("rst_busy", 64'(if_raw.busy), 64'd0);
        check("rst_vn_busy", 64'(if_vn.busy), 64'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // Known pattern gives 0xB2 for a single cycle
        start_collect(1'b0);
        check("busy_collect", 64'(if_raw.busy), 64'd1);
        for (int i = 0; i < 8; i++) drive_tick(pat_b2[i]);
        check("b2_word", 64'(if_raw.out_word), 64'hB2);
        check("b2_valid", 64'(if_raw.out_valid), 64'd1);
        stop_collect();
        check("b2_one_cycle", 64'(if_raw.out_valid), 64'd0);
        check("idle_busy", 64'(if_raw.busy), 64'd0);

        start_collect(1'b0);
        for (int i = 0; i < 24; i++) drive_tick(1'($urandom));
        stop_collect();

        // Partial word abandoned by enable drop must not leak into the next word
        start_collect(1'b0);
        for (int i = 0; i < 5; i++) drive_tick(1'($urandom));
        stop_collect();
        repeat (2) @(negedge clk);
        check("drop_busy", 64'(if_raw.busy), 64'd0);
        start_collect(1'b0);
        for (int i = 0; i < 8; i++) drive_tick(1'($urandom));
        stop_collect();
        check("drop_drain", 64'(sb_raw.size()), 64'd0);

        // Backpressure: second word parks in STALL until the first is taken
        out_ready = 1'b0;
        start_collect(1'b0);
        for (int i = 0; i < 16; i++) drive_tick(1'($urandom));
        check("stall_valid", 64'(if_raw.out_valid), 64'd1);
        check("stall_busy", 64'(if_raw.busy), 64'd1);
        check("stall_word_a", 64'(if_raw.out_word), 64'(sb_raw[0]));
        repeat (5) @(negedge clk);
        check("stall_hold_a", 64'(if_raw.out_word), 64'(sb_raw[0]));
        check("stall_qdepth", 64'(sb_raw.size()), 64'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("resume_word_b", 64'(if_raw.out_word), 64'(sb_raw[0]));
        check("resume_valid", 64'(if_raw.out_valid), 64'd1);
        for (int i = 0; i < 8; i++) drive_tick(1'($urandom));
        stop_collect();
        check("stall_drain", 64'(sb_raw.size()), 64'd0);

        // Von Neumann instance: fixed pair sequence then random raw bits
        vn_phase = 1'b1;
        start_collect(1'b1);
        for (int i = 0; i < 10; i++) drive_tick(pat_vn[i]);
        check("vn_acc_count", 64'(cnt_vn), 64'd3);
        check("vn_acc_bits", 64'(acc_vn[2:0]), 64'h3);
        for (int i = 0; i < 60; i++) drive_tick(1'($urandom));
        stop_collect();
        @(negedge clk);
        check("vn_drain", 64'(sb_vn.size()), 64'd0);
        vn_phase = 1'b0;

        // Reset while stalled with a pending handshake
        out_ready = 1'b0;
        start_collect(1'b0);
        for (int i = 0; i < 16; i++) drive_tick(1'($urandom));
        check("pre_rst_valid", 64'(if_raw.out_valid), 64'd1);
        rst_b = 1'b0;
        en_raw = 1'b0;
        @(negedge clk);
        check("stall_rst_valid", 64'(if_raw.out_valid), 64'd0);
        check("stall_rst_word", 64'(if_raw.out_word), 64'd0);
        check("stall_rst_busy", 64'(if_raw.busy), 64'd0);
        check("stall_rst_health", 64'(if_raw.health_fail), 64'd0);
        sb_raw.delete();
        model_clear();
        rst_b = 1'b1;
        out_ready = 1'b1;
        ro_bits = 4'h0;
        sb_on = 1'b0;
        repeat (3) @(negedge clk);

        // Stuck-at-zero source trips the repetition test on tick 32
        start_collect(1'b0);
        repeat (24 * DECIM) @(negedge clk);
        out_ready = 1'b0;
        repeat (7 * DECIM) @(negedge clk);
        check("rct_31_health", 64'(if_raw.health_fail), 64'd0);
        check("rct_31_valid", 64'(if_raw.out_valid), 64'd1);
        repeat (DECIM) @(negedge clk);
        check("rct_32_health", 64'(if_raw.health_fail), 64'd1);
        check("rct_32_valid", 64'(if_raw.out_valid), 64'd0);
        check("rct_32_busy", 64'(if_raw.busy), 64'd1);
        en_raw = 1'b0;
        repeat (3) @(negedge clk);
        check("fail_en0_health", 64'(if_raw.health_fail), 64'd1);
        check("fail_en0_busy", 64'(if_raw.busy), 64'd1);
        en_raw = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("fail_en1_health", 64'(if_raw.health_fail), 64'd1);
        check("fail_en1_valid", 64'(if_raw.out_valid), 64'd0);
        rst_b = 1'b0;
        en_raw = 1'b0;
        @(negedge clk);
        check("fail_rst_health", 64'(if_raw.health_fail), 64'd0);
        check("fail_rst_busy", 64'(if_raw.busy), 64'd0);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
